// File: rtl/ea_pipe_unit.sv
// ---------------------------------------------------------------------------
// ea_pipe_unit
//
// Purpose:
//   Registered effective-address unit for the LC3 datapath. It selects a base
//   (PC or RS1) and a sign-extended offset from IR (zero, offset6, PCoffset9
//   or PCoffset11), then adds them modulo 2^WIDTH.
//   A valid/ready handshake sits on both sides. An optional indirect mode is
//   used for LDI/STI. In that mode the computed address is issued as a memory
//   read, and the returned word becomes the final EA.
//
// Parameters:
//   WIDTH        address/data width of PC, RS1_DATA, EA, MEM_ADDR, MEM_RDATA
//   INDIRECT_EN  1 = indirect mode supported
//                0 = CONTROL[3] ignored, MEM_REQ tied low
//
// Ports:
//   CLK           clock, rising edge
//   RESET_N       synchronous active-low reset
//   IN_VALID      request present on PC/RS1_DATA/IR/CONTROL
//   IN_READY      unit can accept a request this cycle
//   PC            incremented program counter (base option 0)
//   RS1_DATA      register base (base option 1)
//   IR            instruction; offsets come from IR[5:0], IR[8:0], IR[10:0]
//   CONTROL       [3] indirect, [2] base select (0=PC, 1=RS1),
//                 [1:0] offset select (00=0, 01=off6, 10=off9, 11=off11)
//   MEM_REQ       pointer read request (indirect mode)
//   MEM_ADDR      pointer address, stable while MEM_REQ is high
//   MEM_ACK       read data valid this cycle
//   MEM_RDATA     pointer contents
//   OUT_VALID     EA valid
//   OUT_READY     consumer accepts EA
//   EA            final effective address
//   OUT_INDIRECT  EA came through an indirect fetch
// ---------------------------------------------------------------------------
module ea_pipe_unit #(
  parameter int unsigned WIDTH       = 16,
  parameter bit          INDIRECT_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] RS1_DATA,
  input  logic [15:0]      IR,
  input  logic [3:0]       CONTROL,
  output logic             MEM_REQ,
  output logic [WIDTH-1:0] MEM_ADDR,
  input  logic             MEM_ACK,
  input  logic [WIDTH-1:0] MEM_RDATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] EA,
  output logic             OUT_INDIRECT
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  // State and output registers
  logic [1:0]       state_q,    state_d;
  logic             valid_q,    valid_d;
  logic             req_q,      req_d;
  logic             ind_q,      ind_d;
  logic [WIDTH-1:0] ea_q,       ea_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;

  // Address datapath
  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] offset_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] off6_s;
  logic [WIDTH-1:0] off9_s;
  logic [WIDTH-1:0] off11_s;
  logic             indirect_sel_s;
  logic             in_ready_s;
  logic             accept_s;

  // IR[15:11] carry opcode/register fields that this unit does not need
  logic             unused_ir_s;
  assign unused_ir_s = ^IR[15:11];

  // Offsets are sign-extended from the top bit of each IR field
  assign off6_s  = {{(WIDTH-6){IR[5]}},   IR[5:0]};
  assign off9_s  = {{(WIDTH-9){IR[8]}},   IR[8:0]};
  assign off11_s = {{(WIDTH-11){IR[10]}}, IR[10:0]};

  // Base and offset selection
  always_comb begin
    base_s = PC;
    if (CONTROL[2]) begin
      base_s = RS1_DATA;
    end else begin
      base_s = PC;
    end

    offset_s = {WIDTH{1'b0}};
    case (CONTROL[1:0])
      2'b00:   offset_s = {WIDTH{1'b0}};
      2'b01:   offset_s = off6_s;
      2'b10:   offset_s = off9_s;
      2'b11:   offset_s = off11_s;
      default: offset_s = {WIDTH{1'b0}};
    endcase
  end

  // Modulo-2^WIDTH add; any carry out is intentionally dropped
  assign sum_s = base_s + offset_s;

  // With indirect support compiled out, CONTROL[3] has no effect
  assign indirect_sel_s = INDIRECT_EN & CONTROL[3];

  // A result leaving OUT in this cycle frees the slot for a new request,
  // which gives one request per cycle with no bubble
  assign in_ready_s = (state_q == ST_IDLE) |
                      ((state_q == ST_OUT) & OUT_READY);
  assign accept_s   = IN_VALID & in_ready_s;

  // Next-state logic. Loading a new request is the same from IDLE and OUT.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    req_d      = req_q;
    ind_d      = ind_q;
    ea_d       = ea_q;
    mem_addr_d = mem_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (indirect_sel_s) begin
            mem_addr_d = sum_s;
            req_d      = 1'b1;
            valid_d    = 1'b0;
            state_d    = ST_MEM;
          end else begin
            ea_d    = sum_s;
            ind_d   = 1'b0;
            valid_d = 1'b1;
            state_d = ST_OUT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MEM: begin
        // Request and address stay frozen until the pointer returns
        if (MEM_ACK) begin
          ea_d    = MEM_RDATA;
          ind_d   = 1'b1;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end else begin
          state_d = ST_MEM;
        end
      end

      ST_OUT: begin
        if (OUT_READY) begin
          if (accept_s) begin
            if (indirect_sel_s) begin
              mem_addr_d = sum_s;
              req_d      = 1'b1;
              valid_d    = 1'b0;
              state_d    = ST_MEM;
            end else begin
              ea_d    = sum_s;
              ind_d   = 1'b0;
              valid_d = 1'b1;
              state_d = ST_OUT;
            end
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          // Backpressure: EA and OUT_INDIRECT hold
          state_d = ST_OUT;
        end
      end

      default: begin
        // Unreachable encoding: recover to a quiet idle
        state_d = ST_IDLE;
        valid_d = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      ind_q      <= 1'b0;
      ea_q       <= {WIDTH{1'b0}};
      mem_addr_q <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      ind_q      <= ind_d;
      ea_q       <= ea_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign IN_READY     = in_ready_s;
  assign MEM_REQ      = INDIRECT_EN ? req_q : 1'b0;
  assign MEM_ADDR     = mem_addr_q;
  assign OUT_VALID    = valid_q;
  assign EA           = ea_q;
  assign OUT_INDIRECT = ind_q;

endmodule

// File: tb/tb_ea_pipe_unit.sv
// ---------------------------------------------------------------------------
// tb_ea_pipe_unit
//
// Purpose:
//   Self-checking bench for ea_pipe_unit. It uses three instances:
//     u16    WIDTH=16, INDIRECT_EN=1 (main instance)
//     u_nd   WIDTH=16, INDIRECT_EN=0 (indirect compiled out)
//     u32    WIDTH=32, INDIRECT_EN=1
//   A table of direct vectors is streamed back-to-back. Hand-written
//   sequences then cover the indirect path, backpressure, reset while a
//   memory read is in flight, and the parameter variants.
//   Inputs change 1 ns after the rising edge, and outputs are sampled at
//   the same point.
// ---------------------------------------------------------------------------
module tb_ea_pipe_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] pc;
  logic [15:0] rs1;
  logic [15:0] ir;
  logic [3:0]  ctrl;
  logic        mem_ack;
  logic [15:0] rdata;
  logic        out_ready;

  // Outputs of the main 16-bit instance
  logic        in_ready;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        out_valid;
  logic [15:0] ea;
  logic        out_ind;

  // Outputs of the instance with INDIRECT_EN=0
  logic        nd_in_ready;
  logic        nd_mem_req;
  logic [15:0] nd_mem_addr;
  logic        nd_out_valid;
  logic [15:0] nd_ea;
  logic        nd_out_ind;

  // Inputs and outputs of the 32-bit instance
  logic [31:0] pc32;
  logic [31:0] rs1_32;
  logic [31:0] rdata32;
  logic        w_in_ready;
  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic        w_out_valid;
  logic [31:0] w_ea;
  logic        w_out_ind;

  int n_vec;
  int n_err;

  ea_pipe_unit #(.WIDTH(16), .INDIRECT_EN(1'b1)) u16 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .PC(pc), .RS1_DATA(rs1), .IR(ir), .CONTROL(ctrl),
    .MEM_REQ(mem_req), .MEM_ADDR(mem_addr), .MEM_ACK(mem_ack), .MEM_RDATA(rdata),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .EA(ea), .OUT_INDIRECT(out_ind)
  );

  ea_pipe_unit #(.WIDTH(16), .INDIRECT_EN(1'b0)) u_nd (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(nd_in_ready),
    .PC(pc), .RS1_DATA(rs1), .IR(ir), .CONTROL(ctrl),
    .MEM_REQ(nd_mem_req), .MEM_ADDR(nd_mem_addr), .MEM_ACK(mem_ack), .MEM_RDATA(rdata),
    .OUT_VALID(nd_out_valid), .OUT_READY(out_ready), .EA(nd_ea), .OUT_INDIRECT(nd_out_ind)
  );

  ea_pipe_unit #(.WIDTH(32), .INDIRECT_EN(1'b1)) u32 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(w_in_ready),
    .PC(pc32), .RS1_DATA(rs1_32), .IR(ir), .CONTROL(ctrl),
    .MEM_REQ(w_mem_req), .MEM_ADDR(w_mem_addr), .MEM_ACK(mem_ack), .MEM_RDATA(rdata32),
    .OUT_VALID(w_out_valid), .OUT_READY(out_ready), .EA(w_ea), .OUT_INDIRECT(w_out_ind)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] pc;
    logic [15:0] rs1;
    logic [15:0] ir;
    logic [3:0]  ctrl;
    logic [15:0] exp_ea;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Direct vectors with hand-computed sums
    vecs[0] = '{16'h3000, 16'h0000, 16'h01FF, 4'b0010, 16'h2FFF}; // off9 = -1
    vecs[1] = '{16'h0000, 16'h4000, 16'h0020, 4'b0101, 16'h3FE0}; // off6 = -32
    vecs[2] = '{16'h0000, 16'h4000, 16'h0020, 4'b0100, 16'h4000}; // zero offset
    vecs[3] = '{16'hFFFF, 16'h0000, 16'h0001, 4'b0011, 16'h0000}; // off11 wrap
    vecs[4] = '{16'h1234, 16'h9999, 16'hFFFF, 4'b0000, 16'h1234}; // PC only
    vecs[5] = '{16'h3000, 16'h0000, 16'h0400, 4'b0011, 16'h2C00}; // off11 = -1024
    vecs[6] = '{16'h0000, 16'h0010, 16'h001F, 4'b0101, 16'h002F}; // off6 = +31
    vecs[7] = '{16'h8000, 16'h0000, 16'h00FF, 4'b0010, 16'h80FF}; // off9 = +255
    vecs[8] = '{16'h1000, 16'h0000, 16'hFE05, 4'b0001, 16'h1005}; // IR high bits ignored

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    pc        = 16'h0000;
    rs1       = 16'h0000;
    ir        = 16'h0000;
    ctrl      = 4'b0000;
    mem_ack   = 1'b0;
    rdata     = 16'h0000;
    out_ready = 1'b1;
    pc32      = 32'h0000_0000;
    rs1_32    = 32'h0000_0000;
    rdata32   = 32'h0000_0000;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    check("rst_ea",        {16'd0, ea},        32'd0);
    check("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
    check("rst_out_ind",   {31'd0, out_ind},   32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // Stream the direct table back-to-back: one result per cycle
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pc       = vecs[i].pc;
      rs1      = vecs[i].rs1;
      ir       = vecs[i].ir;
      ctrl     = vecs[i].ctrl;
      in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_ea", i),    {16'd0, ea},        {16'd0, vecs[i].exp_ea});
      check($sformatf("vec%0d_ind", i),   {31'd0, out_ind},   32'd0);
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Indirect: pointer read held for three cycles, then ACK
    out_ready = 1'b0;
    pc        = 16'h3000;
    ir        = 16'h0010;
    ctrl      = 4'b1010;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    pc       = 16'hAAAA;   // must not be re-sampled
    for (int c = 0; c < 3; c++) begin
      check($sformatf("ind_req_c%0d", c),   {31'd0, mem_req},   32'd1);
      check($sformatf("ind_addr_c%0d", c),  {16'd0, mem_addr},  32'h0000_3010);
      check($sformatf("ind_valid_c%0d", c), {31'd0, out_valid}, 32'd0);
      check($sformatf("ind_rdy_c%0d", c),   {31'd0, in_ready},  32'd0);
      if (c < 2) tick();
    end
    mem_ack = 1'b1;
    rdata   = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    check("ind_valid", {31'd0, out_valid}, 32'd1);
    check("ind_ea",    {16'd0, ea},        32'h0000_5A5A);
    check("ind_flag",  {31'd0, out_ind},   32'd1);
    check("ind_req_lo",{31'd0, mem_req},   32'd0);

    // Backpressure for 4 cycles. A stray ACK outside MEM must be ignored.
    pc       = 16'h0100;
    ctrl     = 4'b0000;
    in_valid = 1'b1;
    mem_ack  = 1'b1;
    rdata    = 16'hDEAD;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("bp_rdy_c%0d", c), {31'd0, in_ready}, 32'd0);
      tick();
      check($sformatf("bp_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_ea_c%0d", c),    {16'd0, ea},        32'h0000_5A5A);
      check($sformatf("bp_ind_c%0d", c),   {31'd0, out_ind},   32'd1);
    end
    mem_ack   = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_ea",    {16'd0, ea},        32'h0000_0100);
    check("bp_next_ind",   {31'd0, out_ind},   32'd0);
    in_valid = 1'b0;
    tick();
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);

    // Reset while in MEM, with an ACK arriving the same cycle
    pc       = 16'h3000;
    ir       = 16'h0010;
    ctrl     = 4'b1010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mr_req_before", {31'd0, mem_req}, 32'd1);
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    rdata   = 16'h1111;
    tick();
    check("mr_req",      {31'd0, mem_req},   32'd0);
    check("mr_valid",    {31'd0, out_valid}, 32'd0);
    check("mr_ea",       {16'd0, ea},        32'd0);
    check("mr_addr",     {16'd0, mem_addr},  32'd0);
    check("mr_in_ready", {31'd0, in_ready},  32'd1);
    rst_n = 1'b1;          // ACK still high after release: ignored
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("mr_post_valid_c%0d", c), {31'd0, out_valid}, 32'd0);
      check($sformatf("mr_post_req_c%0d", c),   {31'd0, mem_req},   32'd0);
    end
    mem_ack = 1'b0;

    // INDIRECT_EN=0: CONTROL[3] ignored, direct result in one cycle
    pc       = 16'h3000;
    ir       = 16'h0010;
    ctrl     = 4'b1010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("nd_valid", {31'd0, nd_out_valid}, 32'd1);
    check("nd_ea",    {16'd0, nd_ea},        32'h0000_3010);
    check("nd_ind",   {31'd0, nd_out_ind},   32'd0);
    check("nd_req",   {31'd0, nd_mem_req},   32'd0);
    tick();
    check("nd_req2",   {31'd0, nd_mem_req},  32'd0);
    check("nd_idle",   {31'd0, nd_out_valid},32'd0);
    check("nd_addr",   {16'd0, nd_mem_addr}, 32'd0);
    check("nd_rdy",    {31'd0, nd_in_ready}, 32'd1);

    // WIDTH=32 after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    pc32     = 32'hFFFF_FFF0;
    ir       = 16'h0010;
    ctrl     = 4'b0011;
    in_valid = 1'b1;
    tick();
    check("w_valid", {31'd0, w_out_valid}, 32'd1);
    check("w_ea",    w_ea,                 32'h0000_0000);
    check("w_ind",   {31'd0, w_out_ind},   32'd0);
    rs1_32 = 32'h0000_1000;
    ir     = 16'h0020;
    ctrl   = 4'b0101;
    tick();
    check("w_ea_off6", w_ea, 32'h0000_0FE0);
    pc32 = 32'h1234_0000;
    ir   = 16'h0010;
    ctrl = 4'b1010;
    tick();
    in_valid = 1'b0;
    check("w_req",  {31'd0, w_mem_req},  32'd1);
    check("w_addr", w_mem_addr,          32'h1234_0010);
    check("w_rdy",  {31'd0, w_in_ready}, 32'd0);
    mem_ack = 1'b1;
    rdata32 = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    check("w_ind_valid", {31'd0, w_out_valid}, 32'd1);
    check("w_ind_ea",    w_ea,                 32'hCAFE_F00D);
    check("w_ind_flag",  {31'd0, w_out_ind},   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ea_pipe_unit.md
Name: ea_pipe_unit

Overview:
Registered, parametrised effective-address unit for the LC3 datapath. It takes the same base/offset selection used by the combinational EA logic: base is PC or RS1, offset is zero, offset6, PCoffset9 or PCoffset11. It adds a valid/ready handshake, output backpressure, and an optional indirect mode for LDI/STI. In indirect mode the computed address is issued as a memory read, and the returned word becomes the final EA.

Parameters:
WIDTH, 16, address/data width of PC, RS1_DATA, EA, MEM_ADDR and MEM_RDATA
INDIRECT_EN, 1, 1 = indirect mode supported; 0 = CONTROL[3] ignored, MEM_REQ tied 0

Ports:
CLK  input  1  clock, all state updates on the rising edge
RESET_N  input  1  synchronous, active-low reset
IN_VALID  input  1  request present on the input fields
IN_READY  output  1  unit can accept a request this cycle
PC  input  WIDTH  program counter (incremented PC) base
RS1_DATA  input  WIDTH  register base
IR  input  16  instruction; offset fields IR[5:0], IR[8:0], IR[10:0]
CONTROL  input  4  [2] base select 0=PC 1=RS1; [1:0] offset 00=0, 01=off6, 10=off9, 11=off11; [3] indirect
MEM_REQ  output  1  indirect pointer read request
MEM_ADDR  output  WIDTH  pointer address
MEM_ACK  input  1  read data valid this cycle
MEM_RDATA  input  WIDTH  pointer contents
OUT_VALID  output  1  EA valid
OUT_READY  input  1  consumer accepts EA
EA  output  WIDTH  final effective address
OUT_INDIRECT  output  1  EA came through an indirect fetch

Behaviour:
- Reset (RESET_N=0 at an edge):
  - state=IDLE; OUT_VALID=0, MEM_REQ=0, EA=0, MEM_ADDR=0, OUT_INDIRECT=0.
  - Reset takes priority over every other event, including an in-flight MEM request. A MEM_ACK arriving during or after reset is ignored.
- Offsets:
  - Each offset is sign-extended from its top IR bit to WIDTH.
  - Sum = base + offset, modulo 2^WIDTH. Wrap-around is silent; there is no carry output.
- States: IDLE, MEM, OUT.
- Accept:
  - A request is accepted when IN_VALID & IN_READY at an edge.
  - IN_READY = (state==IDLE) | (state==OUT & OUT_READY). This allows back-to-back throughput of 1 request per cycle with no bubble.
  - Input fields are sampled only on accept and need not be held afterwards.
- Direct path (CONTROL[3]=0 or INDIRECT_EN=0):
  - On accept, EA <= sum, OUT_INDIRECT <= 0, state -> OUT.
  - OUT_VALID is asserted the cycle after accept (latency 1).
- Indirect path (CONTROL[3]=1 and INDIRECT_EN=1):
  - On accept, MEM_ADDR <= sum, MEM_REQ <= 1, state -> MEM.
  - MEM_REQ and MEM_ADDR are held stable until the edge where MEM_ACK=1.
  - At that edge: EA <= MEM_RDATA, OUT_INDIRECT <= 1, MEM_REQ <= 0, state -> OUT.
  - Latency is 2 + the number of cycles waited for MEM_ACK. An ACK in the first MEM cycle gives OUT_VALID 2 cycles after accept.
  - MEM_ACK is ignored outside state MEM.
- OUT state:
  - OUT_VALID=1; EA and OUT_INDIRECT are held stable while OUT_READY=0.
  - On OUT_READY=1: if a new request is accepted the same edge, take its direct or indirect transition. Otherwise go to IDLE with OUT_VALID <= 0.
- In MEM or OUT with OUT_READY=0, IN_READY=0. There is no input buffering and no lost requests.
- MEM_ADDR retains its last value when MEM_REQ=0. Its value is don't-care for consumers.

Test Plan:
- Direct, PC base, off9: WIDTH=16, PC=0x3000, IR[8:0]=0x1FF, CONTROL=0010, OUT_READY=1 -> one cycle later OUT_VALID=1, EA=0x2FFF, OUT_INDIRECT=0.
- RS1 base, off6: RS1_DATA=0x4000, IR[5:0]=0x20, CONTROL=0101 -> EA=0x3FE0. Then CONTROL=0100 -> EA=0x4000. Then off11 with PC=0xFFFF, IR[10:0]=0x001, CONTROL=0011 -> EA=0x0000 (wrap).
- Indirect: PC=0x3000, IR[8:0]=0x010, CONTROL=1010 -> MEM_REQ=1 with MEM_ADDR=0x3010, held 3 cycles. MEM_ACK with MEM_RDATA=0x5A5A -> next cycle OUT_VALID=1, EA=0x5A5A, OUT_INDIRECT=1, MEM_REQ=0.
- Backpressure and streaming:
  - Hold OUT_READY=0 for 4 cycles -> EA stable, IN_READY=0 throughout.
  - Then raise OUT_READY with IN_VALID=1 -> new result the next cycle with no idle cycle.
  - Drive 8 consecutive direct requests -> 8 results on 8 consecutive cycles.
- Reset mid-operation: assert RESET_N=0 while in MEM with MEM_REQ=1, MEM_ACK arriving the same cycle -> next cycle MEM_REQ=0, OUT_VALID=0, EA=0, IN_READY=1. No spurious output after reset is released.
- Parameters: WIDTH=32, PC=0xFFFF_FFF0, IR[10:0]=0x010, CONTROL=0011 -> EA=0x0000_0000. INDIRECT_EN=0 with CONTROL=1010 -> direct result in 1 cycle, MEM_REQ never asserted.
